// File: rtl/alu_slice_pkg.sv
// Shared types, select constants and the 4-bit 74181-style slice function
// used by the sequential ALU.
package alu_slice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_ADD = 4'b1001;
  localparam sel_t SEL_SUB = 4'b0110;
  localparam sel_t SEL_XOR = 4'b0110;

  // Returns {cout, f}. Arithmetic ops are expressed as x + y + cin so the
  // carry out is the true carry of the slice; logic ops never carry.
  function automatic logic [SLICE_W:0] alu181_slice(
    input logic [SLICE_W-1:0] a4,
    input logic [SLICE_W-1:0] b4,
    input sel_t               sel,
    input logic               mode,
    input logic               cin
  );
    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W-1:0] f;
    x = '0;
    y = '0;
    f = '0;
    if (mode) begin
      case (sel)
        4'h0:    f = ~a4;
        4'h1:    f = ~(a4 | b4);
        4'h2:    f = ~a4 & b4;
        4'h3:    f = '0;
        4'h4:    f = ~(a4 & b4);
        4'h5:    f = ~b4;
        4'h6:    f = a4 ^ b4;
        4'h7:    f = a4 & ~b4;
        4'h8:    f = ~a4 | b4;
        4'h9:    f = ~(a4 ^ b4);
        4'hA:    f = b4;
        4'hB:    f = a4 & b4;
        4'hC:    f = '1;
        4'hD:    f = a4 | ~b4;
        4'hE:    f = a4 | b4;
        default: f = a4;
      endcase
      return {1'b0, f};
    end
    case (sel)
      4'h0:    begin x = a4;        y = '0;        end
      4'h1:    begin x = a4 | b4;   y = '0;        end
      4'h2:    begin x = a4 | ~b4;  y = '0;        end
      4'h3:    begin x = '0;        y = '1;        end
      4'h4:    begin x = a4;        y = a4 & ~b4;  end
      4'h5:    begin x = a4 | b4;   y = a4 & ~b4;  end
      4'h6:    begin x = a4;        y = ~b4;       end
      4'h7:    begin x = a4 & ~b4;  y = '1;        end
      4'h8:    begin x = a4;        y = a4 & b4;   end
      4'h9:    begin x = a4;        y = b4;        end
      4'hA:    begin x = a4 | ~b4;  y = a4 & b4;   end
      4'hB:    begin x = a4 & b4;   y = '1;        end
      4'hC:    begin x = a4;        y = a4;        end
      4'hD:    begin x = a4 | b4;   y = a4;        end
      4'hE:    begin x = a4 | ~b4;  y = a4;        end
      default: begin x = a4;        y = '1;        end
    endcase
    return {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-style slice; one link of the per-clock ripple chain.
module alu181_slice
  import alu_slice_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         sel,
  input  logic               mode,
  input  logic               cin,
  output logic [SLICE_W-1:0] f,
  output logic               cout
);

  assign {cout, f} = alu_slice_pkg::alu181_slice(a, b, sel, mode, cin);

endmodule

// File: rtl/alu_slice_seq.sv
// Multi-cycle 74181-style ALU: evaluates WIDTH/4 slices, SPC per clock, LSB
// first, with the ripple carry held in a register between cycles.
//
//   state   | meaning
//   IDLE    | in_ready high, waiting for an operation
//   RUN     | evaluating SPC slices per cycle, carry kept in carry_q
//   DONE    | out_valid high, outputs frozen until out_ready
module alu_slice_seq
  import alu_slice_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeqb,
  output logic             zero
);

  localparam int CHUNK = SLICE_W * SPC;
  localparam int NS    = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;

  if ((SPC < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("alu_slice_seq: WIDTH must be a multiple of 4*SPC and 1 <= SPC <= WIDTH/4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         sel_q;
  logic               mode_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_cyc;
  logic [CHUNK-1:0]   chunk_f;
  logic [SPC:0]       chain;
  logic [WIDTH-1:0]   result_nxt;

  // Operands shift right each RUN cycle so the slices always see bits [CHUNK-1:0].
  assign chain[0] = carry_q;
  for (genvar i = 0; i < SPC; i++) begin : g_slice
    alu181_slice u_slice (
      .a    (a_q[i*SLICE_W +: SLICE_W]),
      .b    (b_q[i*SLICE_W +: SLICE_W]),
      .sel  (sel_q),
      .mode (mode_q),
      .cin  (chain[i]),
      .f    (chunk_f[i*SLICE_W +: SLICE_W]),
      .cout (chain[i+1])
    );
  end

  // Result fills from the top; after NS shifts the LSB slice lands at bit 0.
  if (NS == 1) begin : g_single
    assign result_nxt = chunk_f;
  end else begin : g_multi
    assign result_nxt = {chunk_f, result[WIDTH-1:CHUNK]};
  end

  assign last_cyc = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last_cyc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      aeqb    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sel_q   <= sel;
            mode_q  <= mode;
            carry_q <= cin & ~mode;
            cnt_q   <= CNT_W'(NS - 1);
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= chain[SPC];
          result  <= result_nxt;
          cnt_q   <= cnt_q - CNT_W'(1);
          // Flags come from the completed word so they are ready with out_valid.
          if (last_cyc) begin
            cout <= chain[SPC];
            zero <= (result_nxt == '0);
            aeqb <= &result_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Self-checking bench for alu_slice_seq: a 16-bit/1-slice and a 32-bit/2-slice
// instance checked against a whole-word reference of the 74181 function table.
module tb_alu_slice_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 0, or16 = 0, mode16 = 0, cin16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [3:0]  sel16 = 0;
  logic        ir16, ov16, co16, ae16, z16;
  logic [15:0] res16;

  logic        iv32 = 0, or32 = 0, mode32 = 0, cin32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic [3:0]  sel32 = 0;
  logic        ir32, ov32, co32, ae32, z32;
  logic [31:0] res32;

  int total = 0;
  int bad   = 0;

  alu_slice_seq #(.WIDTH(16), .SPC(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sel(sel16), .mode(mode16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .cout(co16), .aeqb(ae16), .zero(z16)
  );

  alu_slice_seq #(.WIDTH(32), .SPC(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sel(sel32), .mode(mode32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
    .result(res32), .cout(co32), .aeqb(ae32), .zero(z32)
  );

  // Whole-word reference: returns {carry, f}. "-1" terms are added as all-ones
  // and "-B" as ~B, so the carry is the unsigned overflow past bit w-1.
  function automatic logic [32:0] model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                        input logic [3:0] s, input logic m, input logic c);
    logic [63:0] msk, aa, bb, nb, f;
    logic        carry;
    msk = (64'd1 << w) - 64'd1;
    aa  = {32'h0, ai} & msk;
    bb  = {32'h0, bi} & msk;
    nb  = ~bb & msk;
    if (m) begin
      case (s)
        4'h0: f = ~aa;          4'h1: f = ~(aa | bb);
        4'h2: f = ~aa & bb;     4'h3: f = 64'h0;
        4'h4: f = ~(aa & bb);   4'h5: f = ~bb;
        4'h6: f = aa ^ bb;      4'h7: f = aa & nb;
        4'h8: f = ~aa | bb;     4'h9: f = ~(aa ^ bb);
        4'hA: f = bb;           4'hB: f = aa & bb;
        4'hC: f = msk;          4'hD: f = aa | nb;
        4'hE: f = aa | bb;      default: f = aa;
      endcase
      f = f & msk;
      return {1'b0, f[31:0]};
    end
    case (s)
      4'h0: f = aa;
      4'h1: f = aa | bb;
      4'h2: f = aa | nb;
      4'h3: f = msk;
      4'h4: f = aa + (aa & nb);
      4'h5: f = (aa | bb) + (aa & nb);
      4'h6: f = aa + nb;
      4'h7: f = (aa & nb) + msk;
      4'h8: f = aa + (aa & bb);
      4'h9: f = aa + bb;
      4'hA: f = (aa | nb) + (aa & bb);
      4'hB: f = (aa & bb) + msk;
      4'hC: f = aa + aa;
      4'hD: f = (aa | bb) + aa;
      4'hE: f = (aa | nb) + aa;
      default: f = aa + msk;
    endcase
    f = f + {63'h0, c};
    carry = f[w];
    f = f & msk;
    return {carry, f[31:0]};
  endfunction

  // Offers one operation, waits (bounded) for out_valid, samples, then accepts it.
  task automatic run_op(input bit wide, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [3:0] ts, input logic tm, input logic tc,
                        output logic [31:0] r, output logic co, output logic ae,
                        output logic z, output int lat);
    if (wide) begin
      a32 = ta; b32 = tbv; sel32 = ts; mode32 = tm; cin32 = tc; iv32 = 1'b1;
    end else begin
      a16 = ta[15:0]; b16 = tbv[15:0]; sel16 = ts; mode16 = tm; cin16 = tc; iv16 = 1'b1;
    end
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    lat = 0;
    while (!(wide ? ov32 : ov16) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = wide ? res32 : {16'h0, res16};
    co = wide ? co32 : co16;
    ae = wide ? ae32 : ae16;
    z  = wide ? z32 : z16;
    if (wide) or32 = 1'b1; else or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; or32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (ir16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready16 got=%b want=1", ir16); end
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b want=0", ov16); end
    total++; if (res16 !== 16'h0) begin bad++; $display("FAIL reset_result16 got=%h want=0000", res16); end
    total++; if ({co16, ae16, z16} !== 3'b000) begin bad++; $display("FAIL reset_flags16 got=%b want=000", {co16, ae16, z16}); end
    total++; if (ir32 !== 1'b1) begin bad++; $display("FAIL reset_in_ready32 got=%b want=1", ir32); end
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL reset_result32 got=%h want=00000000", res32); end
    total++; if ({ov32, co32, ae32, z32} !== 4'b0000) begin bad++; $display("FAIL reset_flags32 got=%b want=0000", {ov32, co32, ae32, z32}); end
    // out_ready while idle must not disturb anything
    or16 = 1'b1;
    @(posedge clk); #1 or16 = 1'b0;
    total++; if ({ir16, ov16} !== 2'b10) begin bad++; $display("FAIL idle_out_ready got=%b want=10", {ir16, ov16}); end
  endtask

  task automatic test_add();
    logic [31:0] r; logic co, ae, z; int lat;
    run_op(1'b0, 32'hFFFF, 32'h0001, 4'b1001, 1'b0, 1'b0, r, co, ae, z, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
    total++; if (r[15:0] !== 16'h0000) begin bad++; $display("FAIL add_result got=%h want=0000", r[15:0]); end
    total++; if ({co, z, ae} !== 3'b110) begin bad++; $display("FAIL add_flags cout/zero/aeqb got=%b want=110", {co, z, ae}); end
  endtask

  task automatic test_sub();
    logic [31:0] r; logic co, ae, z; int lat;
    run_op(1'b0, 32'h1234, 32'h0234, 4'b0110, 1'b0, 1'b1, r, co, ae, z, lat);
    total++; if (r[15:0] !== 16'h1000) begin bad++; $display("FAIL sub1_result got=%h want=1000", r[15:0]); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL sub1_cout got=%b want=1", co); end
    run_op(1'b0, 32'h0001, 32'h0002, 4'b0110, 1'b0, 1'b1, r, co, ae, z, lat);
    total++; if (r[15:0] !== 16'hFFFF) begin bad++; $display("FAIL sub2_result got=%h want=ffff", r[15:0]); end
    total++; if ({co, ae, z} !== 3'b010) begin bad++; $display("FAIL sub2_flags cout/aeqb/zero got=%b want=010", {co, ae, z}); end
  endtask

  task automatic test_logic();
    logic [31:0] r; logic co, ae, z; int lat;
    run_op(1'b0, 32'hA5A5, 32'h0FF0, 4'b0110, 1'b1, 1'b1, r, co, ae, z, lat);
    total++; if (r[15:0] !== 16'hAA55) begin bad++; $display("FAIL xor_result got=%h want=aa55", r[15:0]); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL xor_cout got=%b want=0", co); end
    run_op(1'b0, 32'hA5A5, 32'h0FF0, 4'b0011, 1'b1, 1'b1, r, co, ae, z, lat);
    total++; if (r[15:0] !== 16'h0000) begin bad++; $display("FAIL zero_result got=%h want=0000", r[15:0]); end
    total++; if ({z, ae, co} !== 3'b100) begin bad++; $display("FAIL zero_flags zero/aeqb/cout got=%b want=100", {z, ae, co}); end
  endtask

  task automatic test_backpressure();
    int lat;
    a16 = 16'h1234; b16 = 16'h4321; sel16 = 4'b1001; mode16 = 1'b0; cin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; sel16 = 4'b1100; cin16 = 1'b1;
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if ({ov16, ir16, res16, co16} !== {1'b1, 1'b0, 16'h5555, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d valid/ready/result/cout got=%b/%b/%h/%b want=1/0/5555/0", i, ov16, ir16, res16, co16);
      end
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(posedge clk); #1 or16 = 1'b0;
    total++; if ({ir16, ov16} !== 2'b10) begin bad++; $display("FAIL bp_release ready/valid got=%b want=10", {ir16, ov16}); end
    total++; if (res16 !== 16'h5555) begin bad++; $display("FAIL bp_result_kept got=%h want=5555", res16); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r; logic co, ae, z; int lat;
    a16 = 16'hFFFF; b16 = 16'hFFFF; sel16 = 4'b1001; mode16 = 1'b0; cin16 = 1'b1; iv16 = 1'b1;
    @(posedge clk); #1 iv16 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++;
    if ({ov16, ir16, res16, co16} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL midrun_reset valid/ready/result/cout got=%b/%b/%h/%b want=0/1/0000/0", ov16, ir16, res16, co16);
    end
    run_op(1'b0, 32'h0003, 32'h0004, 4'b1001, 1'b0, 1'b0, r, co, ae, z, lat);
    total++; if (r[15:0] !== 16'h0007) begin bad++; $display("FAIL after_reset_add got=%h want=0007", r[15:0]); end
    total++; if (lat !== 4) begin bad++; $display("FAIL after_reset_latency got=%0d want=4", lat); end
  endtask

  task automatic test_wide32();
    logic [31:0] r; logic co, ae, z; int lat;
    run_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0, r, co, ae, z, lat);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL w32_add_result got=%h want=80000000", r); end
    total++; if ({co, z, ae} !== 3'b000) begin bad++; $display("FAIL w32_add_flags got=%b want=000", {co, z, ae}); end
    total++; if (lat !== 4) begin bad++; $display("FAIL w32_latency got=%0d want=4", lat); end
    run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0, r, co, ae, z, lat);
    total++; if ({co, z, r} !== {2'b11, 32'h0}) begin bad++; $display("FAIL w32_wrap cout/zero/result got=%b/%b/%h want=1/1/00000000", co, z, r); end
  endtask

  task automatic test_random_sweep();
    logic [31:0] r, ta, tbv, ef, wm; logic co, ae, z, c; int lat, w; logic [32:0] exp;
    for (int wi = 0; wi < 2; wi++) begin
      w  = (wi == 1) ? 32 : 16;
      wm = (wi == 1) ? 32'hFFFFFFFF : 32'h0000FFFF;
      for (int sm = 0; sm < 32; sm++) begin
        for (int k = 0; k < 3; k++) begin
          ta  = $urandom & wm;
          tbv = (k == 2) ? ta : ($urandom & wm);
          c   = 1'($urandom_range(0, 1));
          run_op(wi == 1, ta, tbv, 4'(sm), 1'(sm >> 4), c, r, co, ae, z, lat);
          exp = model(w, ta, tbv, 4'(sm), 1'(sm >> 4), c);
          ef  = exp[31:0];
          total++; if (r !== ef) begin bad++; $display("FAIL sweep_result w=%0d sel=%h mode=%0d a=%h b=%h cin=%0d got=%h want=%h", w, sm[3:0], sm[4], ta, tbv, c, r, ef); end
          total++; if (co !== exp[32]) begin bad++; $display("FAIL sweep_cout w=%0d sel=%h mode=%0d a=%h b=%h cin=%0d got=%b want=%b", w, sm[3:0], sm[4], ta, tbv, c, co, exp[32]); end
          total++; if (z !== (ef == 32'h0)) begin bad++; $display("FAIL sweep_zero w=%0d sel=%h mode=%0d got=%b want=%b", w, sm[3:0], sm[4], z, (ef == 32'h0)); end
          total++; if (ae !== (ef == wm)) begin bad++; $display("FAIL sweep_aeqb w=%0d sel=%h mode=%0d got=%b want=%b", w, sm[3:0], sm[4], ae, (ef == wm)); end
          total++; if (lat !== 4) begin bad++; $display("FAIL sweep_latency w=%0d sel=%h mode=%0d got=%0d want=4", w, sm[3:0], sm[4], lat); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_reset_mid_run();
    test_wide32();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_slice_seq.md
Name: alu_slice_seq

Overview:
- Multi-cycle, parametrised successor to the combinational 16-bit 74181-based ALU.
- Evaluates a WIDTH-bit 74181-style operation as WIDTH/4 four-bit slices, SPC slices per clock, LSB slice first.
- A registered ripple carry links consecutive cycles.
- Sits between the operand/command source and the result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4*SPC (elaboration-time check).
- SPC, 1, 4-bit slices evaluated per clock; 1 <= SPC <= WIDTH/4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  4  74181 function select S3..S0
- mode  in  1  1 = logic, 0 = arithmetic
- cin  in  1  active-high carry in (1 adds one); ignored in logic mode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  F
- cout  out  1  carry out of MSB slice; 0 in logic mode
- aeqb  out  1  all result bits 1 (74181 A=B output, wide-ANDed)
- zero  out  1  result == 0

Behaviour:
- Function table, active-high data, per bit/word.
- Logic mode (mode=1), sel 0..F:
  ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A.
- Arithmetic mode (mode=0), sel 0..F, then +cin:
  A, A|B, A|~B, -1, A+(A&~B), (A|B)+(A&~B), A-B-1, (A&~B)-1, A+(A&B), A+B, (A|~B)+(A&B), (A&B)-1, A+A, (A|B)+A, (A|~B)+A, A-1.
- All arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, sel, mode, cin; slice index <= 0; carry reg <= cin & ~mode; go to RUN.
  - RUN: each cycle evaluate slices idx..idx+SPC-1, write their result bits, update carry reg, idx += SPC. After the cycle that handles the last slice, go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
- Latency: acceptance cycle, then NS = WIDTH/(4*SPC) RUN cycles, then out_valid. Throughput is one operation per NS+2 cycles minimum.
- in_ready=0 in RUN and DONE. Inputs changing while not accepted are ignored.
- out_valid held, with result/cout/aeqb/zero unchanged, until out_ready. out_ready while not out_valid has no effect.
- Logic mode: no inter-slice carry; cout forced 0.
- zero and aeqb are computed from the final result register (registered; no extra cycle).
- Reset (rst=1 at a clk edge), from any state including mid-RUN or DONE:
  - state=IDLE; in_ready=1 from the first cycle after reset.
  - out_valid=0, result=0, cout=0, aeqb=0, zero=0.
  - In-flight operation discarded.

Decomposition:
- Package alu_slice_pkg holds:
  - enum for FSM states;
  - localparam SLICE_W=4;
  - typedef for sel (logic [3:0]);
  - named constants for common selects (SEL_ADD=4'b1001, SEL_SUB=4'b0110, SEL_XOR=4'b0110 logic);
  - function alu181_slice(a4, b4, sel, mode, cin) returning {cout, f[3:0]}.
- One sub-module is natural: alu181_slice (combinational 4-bit slice wrapping the package function). It is instantiated SPC times in a ripple chain inside alu_slice_seq.

Test Plan:
1. WIDTH=16, SPC=1: A=16'hFFFF, B=16'h0001, sel=1001, mode=0, cin=0 → after 4 RUN cycles, result=16'h0000, cout=1, zero=1, aeqb=0.
2. Subtract, sel=0110, mode=0, cin=1: A=16'h1234, B=16'h0234 → result=16'h1000, cout=1. Then A=16'h0001, B=16'h0002 → result=16'hFFFF, cout=0, aeqb=1.
3. Logic XOR, sel=0110, mode=1, cin=1: A=16'hA5A5, B=16'h0FF0 → result=16'hAA55, cout=0 (cin ignored). Then sel=0011 → result=0, zero=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0, new in_valid ignored. Then out_ready=1 for one cycle → IDLE next cycle.
5. Reset mid-RUN (rst at the 2nd RUN cycle) → next cycle out_valid=0, result=0, in_ready=1. A subsequent op 16'h0003+16'h0004 yields 16'h0007.
6. WIDTH=32, SPC=2: A=32'h7FFFFFFF, B=32'h00000001, sel=1001, cin=0 → result 32'h80000000, cout=0, in 4 RUN cycles. Randomised sweep against a reference model for all 32 sel/mode combinations.
